// File: rtl/fp_normalize.sv
`default_nettype none
// ============================================================================
// Module   : fp_normalize
// Brief    : Multi-cycle normalizer turning a 12-bit two's-complement sample
//            into sign, saturated magnitude, leading-zero count, 3-bit
//            exponent, 4-bit significand and rounding bit.
//            Optional macro FP_NORM_FAST_SHIFT_EN enables a 4-bit shift step.
// Revision : 1.0 - initial release
// ============================================================================
module fp_normalize (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] D,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        S,
    output logic [11:0] sign_rep,
    output logic [3:0]  leading_zeros,
    output logic [2:0]  E,
    output logic [3:0]  F,
    output logic        fifth_bit,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ABS   = 2'd1;
    localparam logic [1:0] c_ST_SHIFT = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic [3:0]  c_LZ_MAX  = 4'd8;
    localparam logic [11:0] c_NEG_MIN = 12'h800;
    localparam logic [11:0] c_POS_MAX = 12'h7FF;

    logic [1:0]  r_state;
    logic [11:0] r_d;
    logic [11:0] r_mag;
    logic [11:0] r_sh;
    logic [3:0]  r_lz;

    logic        r_in_ready;
    logic        r_s;
    logic [11:0] r_sign_rep;
    logic [3:0]  r_leading_zeros;
    logic [2:0]  r_e;
    logic [3:0]  r_f;
    logic        r_fifth_bit;
    logic        r_out_valid;

    logic [1:0]  w_next_state;
    logic        w_accept;
    logic [11:0] w_mag;
    logic        w_exit;
    logic [11:0] w_sh_next;
    logic [3:0]  w_lz_next;
    logic [3:0]  w_e_full;

    // in_ready is only ever set while the FSM sits in IDLE
    assign w_accept = r_in_ready & in_valid;

    always_comb begin
        w_mag = r_d;
        if (r_d == c_NEG_MIN) begin
            w_mag = c_POS_MAX;
        end else if (r_d[11]) begin
            w_mag = ~r_d + 12'd1;
        end
    end

    assign w_exit   = r_sh[10] | (r_lz == c_LZ_MAX);
    assign w_e_full = c_LZ_MAX - r_lz;

    always_comb begin
        w_sh_next = r_sh << 1;
        w_lz_next = r_lz + 4'd1;
`ifdef FP_NORM_FAST_SHIFT_EN
        // Four empty top bits with lz<=4 can never overshoot bit 10 or lz=8
        if ((r_sh[10:7] == 4'd0) && (r_lz <= 4'd4)) begin
            w_sh_next = r_sh << 4;
            w_lz_next = r_lz + 4'd4;
        end
`endif
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_accept) w_next_state = c_ST_ABS;
            c_ST_ABS:   w_next_state = c_ST_SHIFT;
            c_ST_SHIFT: if (w_exit) w_next_state = c_ST_DONE;
            c_ST_DONE:  if (out_ready) w_next_state = c_ST_IDLE;
            default:    w_next_state = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_ST_IDLE;
            r_d             <= 12'd0;
            r_mag           <= 12'd0;
            r_sh            <= 12'd0;
            r_lz            <= 4'd0;
            r_in_ready      <= 1'b0;
            r_s             <= 1'b0;
            r_sign_rep      <= 12'd0;
            r_leading_zeros <= 4'd0;
            r_e             <= 3'd0;
            r_f             <= 4'd0;
            r_fifth_bit     <= 1'b0;
            r_out_valid     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state == c_ST_IDLE);
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_d <= D;
                    end
                end
                c_ST_ABS: begin
                    // Magnitude bit 11 is always clear, so counting starts at 1
                    r_mag <= w_mag;
                    r_sh  <= w_mag;
                    r_lz  <= 4'd1;
                end
                c_ST_SHIFT: begin
                    if (w_exit) begin
                        r_s             <= r_d[11];
                        r_sign_rep      <= r_mag;
                        r_leading_zeros <= r_lz;
                        r_e             <= (r_lz < c_LZ_MAX) ? w_e_full[2:0] : 3'd0;
                        r_f             <= r_sh[10:7];
                        r_fifth_bit     <= r_sh[6];
                        r_out_valid     <= 1'b1;
                    end else begin
                        r_sh <= w_sh_next;
                        r_lz <= w_lz_next;
                    end
                end
                c_ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign S             = r_s;
    assign sign_rep      = r_sign_rep;
    assign leading_zeros = r_leading_zeros;
    assign E             = r_e;
    assign F             = r_f;
    assign fifth_bit     = r_fifth_bit;
    assign out_valid     = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_fp_normalize.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_normalize
// Brief    : Self-checking bench for fp_normalize: directed corner samples,
//            backpressure, mid-operation reset and randomized samples.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_normalize;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] D = 12'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        S;
    logic [11:0] sign_rep;
    logic [3:0]  leading_zeros;
    logic [2:0]  E;
    logic [3:0]  F;
    logic        fifth_bit;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        s;
        logic [11:0] mag;
        logic [3:0]  lz;
        logic [2:0]  e;
        logic [3:0]  f;
        logic        fb;
        int          lat;
    } exp_t;

    fp_normalize dut (
        .clk           (clk),
        .rst           (rst),
        .D             (D),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .S             (S),
        .sign_rep      (sign_rep),
        .leading_zeros (leading_zeros),
        .E             (E),
        .F             (F),
        .fifth_bit     (fifth_bit),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the sample value
    function automatic exp_t model(input logic [11:0] d);
        exp_t r;
        int v, cnt, norm, n;
        v = d[11] ? int'(d) - 4096 : int'(d);
        r.s = d[11];
        if (v < 0) v = -v;
        if (v > 2047) v = 2047;
        r.mag = v[11:0];
        cnt = 0;
        for (int i = 11; i >= 0; i--) begin
            if ((v >> i) & 1) break;
            cnt++;
        end
        if (cnt > 8) cnt = 8;
        r.lz = cnt[3:0];
        r.e = (cnt < 8) ? 3'(8 - cnt) : 3'd0;
        norm = v << (cnt - 1);
        r.f  = 4'((norm >> 7) & 15);
        r.fb = 1'((norm >> 6) & 1);
        n = cnt - 1;
`ifdef FP_NORM_FAST_SHIFT_EN
        r.lat = (n >= 4) ? 3 + (n - 4) : 2 + n;
`else
        r.lat = 2 + n;
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, ".S"},         32'(S), 32'd0);
        chk({tag, ".sign_rep"},  32'(sign_rep), 32'd0);
        chk({tag, ".lz"},        32'(leading_zeros), 32'd0);
        chk({tag, ".E"},         32'(E), 32'd0);
        chk({tag, ".F"},         32'(F), 32'd0);
        chk({tag, ".fifth"},     32'(fifth_bit), 32'd0);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".in_ready"},  32'(in_ready), 32'd0);
    endtask

    task automatic chk_outputs(input exp_t x, input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".S"},         32'(S), 32'(x.s));
        chk({tag, ".sign_rep"},  32'(sign_rep), 32'(x.mag));
        chk({tag, ".lz"},        32'(leading_zeros), 32'(x.lz));
        chk({tag, ".E"},         32'(E), 32'(x.e));
        chk({tag, ".F"},         32'(F), 32'(x.f));
        chk({tag, ".fifth"},     32'(fifth_bit), 32'(x.fb));
    endtask

    // Offer a sample from a negedge; returns at the negedge after acceptance
    task automatic send(input logic [11:0] d, input string tag);
        int tmo = 0;
        D = d;
        in_valid = 1'b1;
        while (!in_ready && tmo < 20) begin
            @(negedge clk);
            tmo++;
        end
        chk({tag, ".accept_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits for out_valid, checks latency and outputs
    task automatic collect(input logic [11:0] d, input string tag, output exp_t x);
        int lat = 0;
        x = model(d);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(x.lat));
        chk_outputs(x, tag);
    endtask

    // Hold outputs for 'hold' cycles, then handshake; optionally offer next sample
    task automatic drain(input exp_t x, input string tag, input int hold,
                         input bit offer, input logic [11:0] nd);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk_outputs(x, {tag, ".hold"});
            chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        if (offer) begin
            D = nd;
            in_valid = 1'b1;
        end
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".post_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".post_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_one(input logic [11:0] d, input string tag, input int hold);
        exp_t x;
        send(d, tag);
        collect(d, tag, x);
        drain(x, tag, hold, 1'b0, 12'd0);
    endtask

    initial begin
        exp_t x;
        logic [11:0] rd;

        // Reset state
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("reset.in_ready_after", 32'(in_ready), 32'd1);

        // Directed corners with literal expectations as well as the model
        send(12'h400, "d400"); collect(12'h400, "d400", x);
        chk("d400.lit_E", 32'(E), 32'd7); chk("d400.lit_F", 32'(F), 32'b1000);
        drain(x, "d400", 0, 1'b0, 12'd0);

        send(12'h800, "d800"); collect(12'h800, "d800", x);
        chk("d800.lit_rep", 32'(sign_rep), 32'h7FF); chk("d800.lit_F", 32'(F), 32'b1111);
        chk("d800.lit_fifth", 32'(fifth_bit), 32'd1);
        drain(x, "d800", 0, 1'b0, 12'd0);

        send(12'h03A, "d03A"); collect(12'h03A, "d03A", x);
        chk("d03A.lit_lz", 32'(leading_zeros), 32'd6); chk("d03A.lit_E", 32'(E), 32'd2);
        chk("d03A.lit_F", 32'(F), 32'b1110);
        drain(x, "d03A", 1, 1'b0, 12'd0);

        run_one(12'h000, "d000", 0);

        send(12'hFFF, "dFFF"); collect(12'hFFF, "dFFF", x);
        chk("dFFF.lit_rep", 32'(sign_rep), 32'h001); chk("dFFF.lit_F", 32'(F), 32'b0001);
        chk("dFFF.lit_E", 32'(E), 32'd0);
        drain(x, "dFFF", 0, 1'b0, 12'd0);

        // Backpressure, second sample offered alongside out_ready
        send(12'h123, "bp"); collect(12'h123, "bp", x);
        drain(x, "bp", 5, 1'b1, 12'hE5C);
        send(12'hE5C, "bp2"); collect(12'hE5C, "bp2", x);
        drain(x, "bp2", 0, 1'b0, 12'd0);

        // Reset pulsed in SHIFT, with nonzero outputs still held from before
        send(12'h001, "rstmid");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_zero_outputs("rstmid");
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid.in_ready_after", 32'(in_ready), 32'd1);
        send(12'h7FF, "d7FF"); collect(12'h7FF, "d7FF", x);
        chk("d7FF.lit_E", 32'(E), 32'd7); chk("d7FF.lit_F", 32'(F), 32'b1111);
        chk("d7FF.lit_fifth", 32'(fifth_bit), 32'd1);
        drain(x, "d7FF", 0, 1'b0, 12'd0);

        // Randomized samples with random consumer stalls
        for (int i = 0; i < 40; i++) begin
            rd = 12'($urandom);
            if (i % 4 == 0) rd = 12'($urandom_range(0, 15));
            run_one(rd, $sformatf("rnd%0d_%03h", i, rd), int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
